// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback front end: source encoding and FIFO entry layout.
package writeback_arbiter_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 4;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// In-order DEPTH-entry FIFO for writeback entries; head reads as zero when empty.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ENTRY_W-1:0]           wr_entry,
    output logic [ENTRY_W-1:0]           rd_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rd_entry = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin ALU/load writeback arbiter feeding an in-order FIFO that drains onto the register file port.
// Define WRITEBACK_SCOREBOARD_EN to build the per-register pending-write counters behind reg_busy.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic                         wb_stall,
    output logic [DATA_W-1:0]            port_c,
    output logic [ADDR_W-1:0]            decoder_control,
    output logic                         load_enable,
    output logic [(1 << ADDR_W)-1:0]     reg_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    src_e      last_grant;
    src_e      grant;
    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;

    // A lone requester always wins; a tie goes to whichever source was not granted last.
    always_comb begin
        grant = SRC_ALU;
        if (alu_valid && !mem_valid) begin
            grant = SRC_ALU;
        end else if (mem_valid && !alu_valid) begin
            grant = SRC_MEM;
        end else begin
            grant = (last_grant == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
    end

    assign alu_ready = reset_n && !fifo_full && (grant == SRC_ALU);
    assign mem_ready = reset_n && !fifo_full && (grant == SRC_MEM);
    assign push      = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign pop       = !fifo_empty && !wb_stall;

    always_comb begin
        push_entry = '0;
        if (grant == SRC_MEM) begin
            push_entry.addr = WB_ADDR_W'(mem_addr);
            push_entry.data = WB_DATA_W'(mem_data);
        end else begin
            push_entry.addr = WB_ADDR_W'(alu_addr);
            push_entry.data = WB_DATA_W'(alu_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= SRC_MEM;
        end else if (push) begin
            last_grant <= grant;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (push_entry),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // The register file captures on the same edge that pops the head.
    assign load_enable     = pop;
    assign port_c          = DATA_W'(head_entry.data);
    assign decoder_control = ADDR_W'(head_entry.addr);

`ifdef WRITEBACK_SCOREBOARD_EN
    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] busy_cnt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            inc_vec[r] = push && (push_entry.addr == WB_ADDR_W'(r));
            dec_vec[r] = pop && (head_entry.addr == WB_ADDR_W'(r));
        end
    end

    // Simultaneous push and pop to the same register leave its count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                busy_cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    busy_cnt[r] <= busy_cnt[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    busy_cnt[r] <= busy_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        reg_busy = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            reg_busy[r] = (busy_cnt[r] != '0);
        end
    end
`else
    assign reg_busy = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; expected writes are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_writeback_arbiter;

`ifdef WRITEBACK_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wb_stall;
    logic [31:0] port_c;
    logic [3:0]  decoder_control;
    logic        load_enable;
    logic [15:0] reg_busy;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_addr        (alu_addr),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .wb_stall        (wb_stall),
        .port_c          (port_c),
        .decoder_control (decoder_control),
        .load_enable     (load_enable),
        .reg_busy        (reg_busy),
        .fifo_count      (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (load_enable === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write",
                             decoder_control, port_c);
                end else begin
                    e = exp_q.pop_front();
                    if (decoder_control !== e.addr || port_c !== e.data) begin
                        n_errors++;
                        $display("FAIL write_order: got r%0d=0x%0h, expected r%0d=0x%0h",
                                 decoder_control, port_c, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 4'd0;
        alu_data  = 32'h0;
        mem_valid = 1'b1;
        mem_addr  = 4'd0;
        mem_data  = 32'h0;
        wb_stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_load_enable", 32'(load_enable), 32'h0);
        check("rst_alu_ready", 32'(alu_ready), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_reg_busy", 32'(reg_busy), 32'h0);
        check("rst_port_c", port_c, 32'h0);
        check("rst_decoder_control", 32'(decoder_control), 32'h0);
        reset_n   = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();

        // Single ALU write: one-cycle latency to the register file.
        alu_valid = 1'b1;
        alu_addr  = 4'd3;
        alu_data  = 32'hDEADBEEF;
        settle();
        check("t1_alu_ready", 32'(alu_ready), 32'h1);
        check("t1_mem_ready", 32'(mem_ready), 32'h0);
        expect_write(4'd3, 32'hDEADBEEF);
        step();
        alu_valid = 1'b0;
        settle();
        check("t1_load_enable", 32'(load_enable), 32'h1);
        check("t1_decoder_control", 32'(decoder_control), 32'd3);
        check("t1_port_c", port_c, 32'hDEADBEEF);
        check("t1_reg_busy3", 32'(reg_busy[3]), 32'(SB));
        check("t1_fifo_count", 32'(fifo_count), 32'd1);
        step();
        settle();
        check("t1_load_enable_off", 32'(load_enable), 32'h0);
        check("t1_reg_busy_off", 32'(reg_busy), 32'h0);
        check("t1_fifo_count_off", 32'(fifo_count), 32'd0);

        // Both valid every cycle; last grant was ALU so MEM wins the first tie.
        step();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'd1;
            alu_data  = 32'hA0 + 32'(i);
            mem_valid = 1'b1;
            mem_addr  = 4'd2;
            mem_data  = 32'hB0 + 32'(i);
            settle();
            check("t2_alu_ready", 32'(alu_ready), 32'(i % 2 == 1));
            check("t2_mem_ready", 32'(mem_ready), 32'(i % 2 == 0));
            check("t2_fifo_count", 32'(fifo_count), (i == 0) ? 32'd0 : 32'd1);
            check("t2_load_enable", 32'(load_enable), (i == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 1) expect_write(4'd1, 32'hA0 + 32'(i));
            else            expect_write(4'd2, 32'hB0 + 32'(i));
            step();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        step();

        // Fill under stall: fifth push refused, no push-through while full.
        wb_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'(8 + i);
            alu_data  = 32'h300 + 32'(i);
            settle();
            check("t3_alu_ready", 32'(alu_ready), 32'(i < 4));
            check("t3_fifo_count", 32'(fifo_count), 32'(i));
            check("t3_load_enable", 32'(load_enable), 32'h0);
            if (i < 4) expect_write(4'(8 + i), 32'h300 + 32'(i));
            step();
        end
        wb_stall = 1'b0;
        settle();
        check("t3_full_pop_alu_ready", 32'(alu_ready), 32'h0);
        check("t3_full_pop_load_enable", 32'(load_enable), 32'h1);
        check("t3_full_fifo_count", 32'(fifo_count), 32'd4);
        step();
        alu_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            check("t3_drain_fifo_count", 32'(fifo_count), 32'(4 - k));
            check("t3_drain_load_enable", 32'(load_enable), 32'h1);
            step();
        end
        settle();
        check("t3_empty_fifo_count", 32'(fifo_count), 32'd0);
        check("t3_empty_load_enable", 32'(load_enable), 32'h0);

        // Two queued writes to r7 from different sources land in acceptance order.
        step();
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        alu_addr  = 4'd7;
        alu_data  = 32'h1;
        settle();
        check("t4_alu_ready", 32'(alu_ready), 32'h1);
        expect_write(4'd7, 32'h1);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = 4'd7;
        mem_data  = 32'h2;
        settle();
        check("t4_mem_ready", 32'(mem_ready), 32'h1);
        expect_write(4'd7, 32'h2);
        step();
        mem_valid = 1'b0;
        settle();
        check("t4_reg_busy7_queued", 32'(reg_busy[7]), 32'(SB));
        check("t4_fifo_count", 32'(fifo_count), 32'd2);
        step();
        wb_stall = 1'b0;
        settle();
        check("t4_load_enable_first", 32'(load_enable), 32'h1);
        check("t4_reg_busy7_first", 32'(reg_busy[7]), 32'(SB));
        step();
        settle();
        check("t4_load_enable_second", 32'(load_enable), 32'h1);
        check("t4_reg_busy7_second", 32'(reg_busy[7]), 32'(SB));
        step();
        settle();
        check("t4_reg_busy7_clear", 32'(reg_busy[7]), 32'h0);
        check("t4_fifo_count_clear", 32'(fifo_count), 32'd0);

        // Push to r5 on the same edge its only queued write pops.
        step();
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        alu_addr  = 4'd5;
        alu_data  = 32'h55;
        settle();
        check("t5_alu_ready_first", 32'(alu_ready), 32'h1);
        expect_write(4'd5, 32'h55);
        step();
        wb_stall = 1'b0;
        alu_data = 32'h56;
        settle();
        check("t5_alu_ready_second", 32'(alu_ready), 32'h1);
        check("t5_load_enable", 32'(load_enable), 32'h1);
        check("t5_reg_busy5_before", 32'(reg_busy[5]), 32'(SB));
        expect_write(4'd5, 32'h56);
        step();
        alu_valid = 1'b0;
        settle();
        check("t5_reg_busy5_after", 32'(reg_busy[5]), 32'(SB));
        check("t5_fifo_count", 32'(fifo_count), 32'd1);
        step();
        settle();
        check("t5_reg_busy5_clear", 32'(reg_busy[5]), 32'h0);
        check("t5_fifo_count_clear", 32'(fifo_count), 32'd0);

        // Reset mid-drain discards queued entries and suppresses writes.
        step();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'(9 + i);
            alu_data  = 32'h600 + 32'(i);
            settle();
            check("t6_alu_ready", 32'(alu_ready), 32'h1);
            expect_write(4'(9 + i), 32'h600 + 32'(i));
            step();
        end
        alu_valid = 1'b0;
        wb_stall  = 1'b0;
        settle();
        check("t6_fifo_count_queued", 32'(fifo_count), 32'd3);
        check("t6_load_enable_drain", 32'(load_enable), 32'h1);
        step();
        settle();
        check("t6_fifo_count_mid", 32'(fifo_count), 32'd2);
        reset_n = 1'b0;
        exp_q.delete();
        alu_valid = 1'b1;
        alu_addr  = 4'd13;
        alu_data  = 32'h700;
        mem_valid = 1'b1;
        mem_addr  = 4'd14;
        mem_data  = 32'h800;
        #1;
        check("t6_rst_load_enable", 32'(load_enable), 32'h0);
        check("t6_rst_fifo_count", 32'(fifo_count), 32'h0);
        check("t6_rst_reg_busy", 32'(reg_busy), 32'h0);
        check("t6_rst_alu_ready", 32'(alu_ready), 32'h0);
        check("t6_rst_mem_ready", 32'(mem_ready), 32'h0);
        check("t6_rst_port_c", port_c, 32'h0);
        check("t6_rst_decoder_control", 32'(decoder_control), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        settle();
        check("t6_post_fifo_count", 32'(fifo_count), 32'd0);
        check("t6_post_tie_alu_ready", 32'(alu_ready), 32'h1);
        check("t6_post_tie_mem_ready", 32'(mem_ready), 32'h0);
        expect_write(4'd13, 32'h700);
        step();
        settle();
        check("t6_second_tie_alu_ready", 32'(alu_ready), 32'h0);
        check("t6_second_tie_mem_ready", 32'(mem_ready), 32'h1);
        expect_write(4'd14, 32'h800);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (3) step();
        check("final_outstanding_writes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
